// File: rtl/onehot_pkg.sv
// Shared constants and output-stage state type for the one-hot / binary
// conversion blocks.
package onehot_pkg;

  localparam int ONE_HOT_W = 16;
  localparam int BIN_W     = 4;
  localparam int ERR_CNT_W = 8;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } ostate_e;

endpackage

// File: rtl/onehot_scan.sv
// Combinational one-hot scanner: lowest set index plus zero / multi-bit flags.
module onehot_scan #(
  parameter int ONE_HOT_W = 16,
  parameter int BIN_W     = 4
) (
  input  logic [ONE_HOT_W-1:0] one_hot,
  output logic [BIN_W-1:0]     idx,
  output logic                 zero,
  output logic                 multi
);

  logic found;

  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < ONE_HOT_W; i++) begin
      if (one_hot[i] && !found) begin
        idx   = BIN_W'(i);
        found = 1'b1;
      end
    end
  end

  assign zero  = ~|one_hot;
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi = |(one_hot & (one_hot - ONE_HOT_W'(1)));

endmodule

// File: rtl/onehot_to_bin_pipe.sv
// One-hot to binary decoder with a single valid/ready output register and
// saturating error statistics for malformed input words.
module onehot_to_bin_pipe
  import onehot_pkg::*;
#(
  parameter int ONE_HOT_W = onehot_pkg::ONE_HOT_W,
  parameter int BIN_W     = onehot_pkg::BIN_W,
  parameter int ERR_CNT_W = onehot_pkg::ERR_CNT_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [ONE_HOT_W-1:0] one_hot_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [BIN_W-1:0]     bin_o,
  output logic                 err_o,
  input  logic                 clr_err_i,
  output logic                 err_sticky_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o
);

  if (ONE_HOT_W < 2) begin : g_bad_onehot_w
    $error("onehot_to_bin_pipe: ONE_HOT_W must be >= 2");
  end
  if (BIN_W != $clog2(ONE_HOT_W)) begin : g_bad_bin_w
    $error("onehot_to_bin_pipe: BIN_W must equal $clog2(ONE_HOT_W)");
  end

  ostate_e          state, state_n;
  logic [BIN_W-1:0] scan_idx;
  logic             scan_zero, scan_multi;
  logic             scan_err;
  logic             accept, transfer;

  onehot_scan #(
    .ONE_HOT_W (ONE_HOT_W),
    .BIN_W     (BIN_W)
  ) u_scan (
    .one_hot (one_hot_i),
    .idx     (scan_idx),
    .zero    (scan_zero),
    .multi   (scan_multi)
  );

  assign scan_err    = scan_zero | scan_multi;
  assign out_valid_o = (state == FULL);

  always_comb begin
    state_n    = state;
    in_ready_o = !reset && ((state == EMPTY) || out_ready_i);
    accept     = in_valid_i && in_ready_o;
    transfer   = (state == FULL) && out_ready_i;
    case (state)
      EMPTY:   if (accept) state_n = FULL;
      FULL:    if (transfer && !accept) state_n = EMPTY;
      default: state_n = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= EMPTY;
      bin_o        <= '0;
      err_o        <= 1'b0;
      err_cnt_o    <= '0;
      err_sticky_o <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        bin_o <= scan_idx;
        err_o <= scan_err;
      end
      // Clear wins over a same-cycle bad word; statistics ignore backpressure.
      if (clr_err_i) begin
        err_cnt_o    <= '0;
        err_sticky_o <= 1'b0;
      end else if (accept && scan_err) begin
        err_sticky_o <= 1'b1;
        if (err_cnt_o != '1) err_cnt_o <= err_cnt_o + ERR_CNT_W'(1);
      end
    end
  end

endmodule
